// File: rtl/freq_meas.sv
// rtl/freq_meas.sv - period / high-time measurement of an asynchronous pulse train
//
// Purpose:
//   Synchronizes sig_in into the clk domain, then counts clk cycles between
//   consecutive rising edges (period) and cycles spent high (high_time).
//   Each completed period is strobed with a one-cycle valid.  A sticky
//   timeout flags an input that stops rising within TIMEOUT cycles.
//
// Configuration macro:
//   FREQ_MEAS_DUTY_EN - when defined the high-time counter is built;
//                       when undefined high_time is tied to zero.
//
// Ports:
//   clk        in   1          system clock, posedge
//   rst_n      in   1          asynchronous active-low reset
//   en         in   1          measurement enable (level)
//   sig_in     in   1          asynchronous signal to measure
//   period     out  CNT_WIDTH  clk cycles between the last two rises
//   high_time  out  CNT_WIDTH  clk cycles sig was high in that period
//   valid      out  1          one-cycle strobe: period/high_time updated
//   timeout    out  1          sticky: no rise within TIMEOUT cycles

module freq_meas #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned TIMEOUT     = 48000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   h_q;
    logic                   s;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    // Synchronizer chain; the newest sample enters at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            h_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            h_q    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    // Edge-based, so a level that is already high when enabled never arms.
    assign rise = s & ~h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_RUN;
                        cnt_d   = ONE_C;
                    end
                end
                ST_RUN: begin
                    // A rise on the timeout cycle still closes a valid period.
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = ONE_C;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef FREQ_MEAS_DUTY_EN
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    // Follows the same decisions as the period counter; the rise cycle
    // itself is high, so a fresh period starts at one.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (!en) begin
            hcnt_d = '0;
        end else if (state_q == ST_ARM) begin
            if (rise) begin
                hcnt_d = ONE_C;
            end
        end else if (state_q == ST_RUN) begin
            if (rise) begin
                high_d = hcnt_q;
                hcnt_d = ONE_C;
            end else if (cnt_q == TIMEOUT_C) begin
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_q + CNT_WIDTH'(s);
            end
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_freq_meas.sv
// tb/tb_freq_meas.sv - self-checking bench for freq_meas

module tb_freq_meas;

    localparam int CW = 32;
    localparam int TO = 100;
    localparam int SS = 2;
    localparam int HN = 16384;
`ifdef FREQ_MEAS_DUTY_EN
    localparam int DUTY = 1;
`else
    localparam int DUTY = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          timeout;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;
    int v0     = 0;

    always #5 clk = ~clk;

    freq_meas #(
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the synchronizer is a pure delay; periods are differences of
    // rise-detect timestamps and high time is a sum over the sample history.
    bit          line [SS];
    bit          h_m;
    bit          shist [HN];
    int          mmode = 0;      // 0 idle, 1 waiting for arming rise, 2 measuring
    int          last_rise = 0;
    int          k = 0;
    int          sum;
    bit          s_b;
    bit          rise_b;
    logic [CW-1:0] e_period  = '0;
    logic [CW-1:0] e_high    = '0;
    bit            e_valid   = 1'b0;
    bit            e_timeout = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) line[i] = 1'b0;
            h_m       = 1'b0;
            mmode     = 0;
            e_period  = '0;
            e_high    = '0;
            e_valid   = 1'b0;
            e_timeout = 1'b0;
        end else begin
            s_b    = line[SS-1];
            rise_b = s_b & ~h_m;
            shist[k % HN] = s_b;
            e_valid = 1'b0;
            if (!en) begin
                mmode     = 0;
                e_timeout = 1'b0;
            end else if (mmode == 0) begin
                mmode = 1;
            end else if (mmode == 1) begin
                if (rise_b) begin
                    mmode     = 2;
                    last_rise = k;
                end
            end else begin
                if (rise_b) begin
                    sum = 0;
                    for (int j = last_rise; j < k; j++) sum += int'(shist[j % HN]);
                    e_period  = CW'(k - last_rise);
                    e_high    = CW'(sum * DUTY);
                    e_valid   = 1'b1;
                    e_timeout = 1'b0;
                    last_rise = k;
                end else if (k - last_rise == TO) begin
                    e_timeout = 1'b1;
                    mmode     = 1;
                end
            end
            h_m = s_b;
            for (int i = SS - 1; i > 0; i--) line[i] = line[i-1];
            line[0] = sig_in;
        end
        k++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_period", period, 0);
            check("rst_high_time", high_time, 0);
            check("rst_valid", valid, 0);
            check("rst_timeout", timeout, 0);
        end else begin
            check("period", period, e_period);
            check("high_time", high_time, e_high);
            check("valid", valid, e_valid);
            check("timeout", timeout, e_timeout);
        end
        if (valid === 1'b1) vcnt++;
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            sig_in = v;
            @(posedge clk);
            #3;
        end
    endtask

    task automatic rise_gap(input int g);
        drive(1'b1, 1);
        drive(1'b0, g - 1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        #3;
        drive(1'b0, 3);
        settle();
        check("lit_reset_period", period, 0);
        check("lit_reset_valid", valid, 0);
        rst_n = 1'b1;
        drive(1'b0, 3);
        en = 1'b1;
        drive(1'b0, 4);

        // /4 divider, 50% duty: first rise only arms
        v0 = vcnt;
        repeat (10) begin
            drive(1'b1, 2);
            drive(1'b0, 2);
        end
        settle();
        check("t1_valid_count", vcnt - v0, 9);
        check("t1_period", period, 4);
        check("t1_high_time", high_time, 2 * DUTY);

        // 3 high / 7 low
        v0 = vcnt;
        repeat (4) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        settle();
        check("t2_valid_count", vcnt - v0, 4);
        check("t2_period", period, 10);
        check("t2_high_time", high_time, 3 * DUTY);

        // stall low -> timeout, then rises 20 apart
        v0 = vcnt;
        drive(1'b0, 110);
        settle();
        check("t3_timeout", timeout, 1);
        check("t3_no_valid", vcnt - v0, 0);
        check("t3_period_hold", period, 10);
        rise_gap(20);
        rise_gap(20);
        settle();
        check("t3_timeout_clear", timeout, 0);
        check("t3_period", period, 20);
        check("t3_valid_count", vcnt - v0, 1);

        // rises exactly TIMEOUT apart, then TIMEOUT+1 apart
        rise_gap(100);
        drive(1'b1, 1);
        drive(1'b0, 10);
        settle();
        check("t4_period_max", period, 100);
        check("t4_timeout_max", timeout, 0);
        drive(1'b0, 90);
        v0 = vcnt;
        rise_gap(10);
        settle();
        check("t4_timeout_101", timeout, 1);
        check("t4_rearm_no_valid", vcnt - v0, 0);
        check("t4_period_hold", period, 100);
        rise_gap(10);
        settle();
        check("t4_period_after", period, 10);
        check("t4_timeout_after", timeout, 0);

        // en drop mid-run, re-enable with input held high
        rise_gap(8);
        rise_gap(8);
        v0 = vcnt;
        en = 1'b0;
        drive(1'b1, 3);
        en = 1'b1;
        drive(1'b1, 10);
        settle();
        check("t5_no_valid", vcnt - v0, 0);
        check("t5_period_hold", period, 8);
        drive(1'b0, 3);
        rise_gap(7);
        settle();
        check("t5_arm_only", vcnt - v0, 0);
        rise_gap(7);
        settle();
        check("t5_valid_count", vcnt - v0, 1);
        check("t5_period", period, 7);

        // reset mid-run
        rise_gap(6);
        rise_gap(6);
        rise_gap(6);
        settle();
        check("t6_period_before", period, 6);
        rst_n = 1'b0;
        settle();
        check("t6_rst_period", period, 0);
        check("t6_rst_high", high_time, 0);
        drive(1'b1, 2);
        rst_n = 1'b1;
        drive(1'b0, 3);
        v0 = vcnt;
        rise_gap(9);
        settle();
        check("t6_arm_only", vcnt - v0, 0);
        rise_gap(9);
        settle();
        check("t6_valid_count", vcnt - v0, 1);
        check("t6_period", period, 9);
        check("t6_high_time", high_time, 1 * DUTY);

        drive(1'b0, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
